// File: rtl/aes_add_round_key_stage_pkg.sv
// Shared definitions for the AddRoundKey stage: widths, round count,
// the FSM encoding and the round-constant table used by the key schedule.
package aes_add_round_key_stage_pkg;

  localparam int BYTE     = 8;
  localparam int WORD     = 32;
  localparam int SENTENCE = 128;
  localparam int NROUNDS  = 10;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Round constant used when deriving round key r+1 from round key r.
  function automatic logic [BYTE-1:0] rcon(input logic [3:0] r);
    case (r)
      4'd0:    rcon = 8'h01;
      4'd1:    rcon = 8'h02;
      4'd2:    rcon = 8'h04;
      4'd3:    rcon = 8'h08;
      4'd4:    rcon = 8'h10;
      4'd5:    rcon = 8'h20;
      4'd6:    rcon = 8'h40;
      4'd7:    rcon = 8'h80;
      4'd8:    rcon = 8'h1b;
      4'd9:    rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box, purely combinational.
//   a_i : input byte
//   s_o : substituted byte
// Computed as multiplicative inverse in GF(2^8) (x^254) followed by the
// AES affine transform, so no 256-entry table has to be maintained.
module aes_sbox
  import aes_add_round_key_stage_pkg::*;
(
  input  logic [BYTE-1:0] a_i,
  output logic [BYTE-1:0] s_o
);

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] sq, inv;

  // x^254 = x^2 * x^4 * ... * x^128; maps 0 to 0 as AES requires.
  always_comb begin
    sq  = a_i;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
  end

  assign s_o = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;

endmodule

// File: rtl/aes_add_round_key_stage.sv
// Registered AddRoundKey stage with on-the-fly AES-128 key expansion.
//   clk, rst_n          : clock, synchronous active-low reset
//   start, key_in       : load cipher key as round key 0 and begin a block
//   in_valid/in_ready   : upstream handshake, in_data = state to whiten
//   out_valid/out_ready : downstream handshake, out_data = in_data ^ round key
//   round               : index of round key applied to the next accept
//   busy                : key schedule active
//   done                : pulse when the round-10 result is registered
module aes_add_round_key_stage
  import aes_add_round_key_stage_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [SENTENCE-1:0] key_in,
  input  logic                in_valid,
  input  logic [SENTENCE-1:0] in_data,
  output logic                in_ready,
  output logic                out_valid,
  output logic [SENTENCE-1:0] out_data,
  input  logic                out_ready,
  output logic [3:0]          round,
  output logic                busy,
  output logic                done
);

  state_e              state_q, state_d;
  logic [SENTENCE-1:0] key_q, key_d;
  logic [3:0]          round_q, round_d;
  logic                ov_q, ov_d;
  logic [SENTENCE-1:0] od_q, od_d;
  logic                done_q, done_d;

  logic                accept;
  logic [WORD-1:0]     rot, sub, t;
  logic [WORD-1:0]     c0n, c1n, c2n, c3n;

  // RotWord of the last column: row 0 (MSB byte) moves to row 3.
  assign rot = {key_q[23:0], key_q[31:24]};

  for (genvar g = 0; g < WORD/BYTE; g++) begin : g_subword
    aes_sbox u_sbox (
      .a_i (rot[g*BYTE +: BYTE]),
      .s_o (sub[g*BYTE +: BYTE])
    );
  end

  assign t   = sub ^ {rcon(round_q), 24'h0};
  assign c0n = key_q[127:96] ^ t;
  assign c1n = key_q[95:64]  ^ c0n;
  assign c2n = key_q[63:32]  ^ c1n;
  assign c3n = key_q[31:0]   ^ c2n;

  // start wins over any same-cycle input, so it also blocks the handshake.
  assign in_ready = (state_q == RUN) & ~start & (out_ready | ~ov_q);
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    round_d = round_q;
    ov_d    = ov_q;
    od_d    = od_q;
    done_d  = 1'b0;
    if (start) begin
      state_d = RUN;
      key_d   = key_in;
      round_d = 4'd0;
      ov_d    = 1'b0;
    end else if (accept) begin
      od_d = in_data ^ key_q;
      ov_d = 1'b1;
      if (round_q == 4'(NROUNDS)) begin
        done_d  = 1'b1;
        state_d = IDLE;
        round_d = 4'd0;
      end else begin
        round_d = round_q + 4'd1;
        key_d   = {c0n, c1n, c2n, c3n};
      end
    end else if (out_ready) begin
      ov_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      key_q   <= '0;
      round_q <= '0;
      ov_q    <= 1'b0;
      od_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      round_q <= round_d;
      ov_q    <= ov_d;
      od_q    <= od_d;
      done_q  <= done_d;
    end
  end

  assign out_valid = ov_q;
  assign out_data  = od_q;
  assign round     = round_q;
  assign busy      = (state_q == RUN);
  assign done      = done_q;

endmodule

// File: tb/tb_aes_add_round_key_stage.sv
module tb_aes_add_round_key_stage;

  logic         clk = 1'b0;
  logic         rst_n, start, in_valid, out_ready;
  logic [127:0] key_in, in_data;
  logic         in_ready, out_valid, busy, done;
  logic [127:0] out_data;
  logic [3:0]   round;

  aes_add_round_key_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .key_in    (key_in),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .round     (round),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT  = 128'h3243f6a8885a308d313198a2e0370734;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]   sb [256];
  logic [127:0] rk [11];

  // model: one-entry output queue, running flag, block count, done pulse
  logic [127:0] m_q [$];
  bit           m_run, m_done;
  int           m_rnd;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    int acc, x;
    acc = 0;
    x   = int'(a);
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = x << 1;
      if (x > 255) x = x ^ 'h11b;
    end
    return acc[7:0];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gm(x[7:0], y[7:0]) == 8'h01) inv = y[7:0];
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8];
      sb[x] = s ^ 8'h63;
    end
  endtask

  // FIPS-197 KeyExpansion for Nk=4, Nr=10
  task automatic expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]};
        tmp = tmp ^ {rc, 24'h0};
        rc  = gm(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // One clock: drive inputs, compare DUT against model, advance the model.
  task automatic cyc(input logic r, input logic s, input logic [127:0] k,
                     input logic v, input logic [127:0] d, input logic ordy);
    bit drain, acc;
    @(negedge clk);
    rst_n = r; start = s; key_in = k; in_valid = v; in_data = d; out_ready = ordy;
    #1;
    chk("out_valid", out_valid, m_q.size() != 0);
    if (m_q.size() != 0) chk("out_data", out_data, m_q[0]);
    chk("round", round, m_rnd);
    chk("busy", busy, m_run);
    chk("done", done, m_done);
    chk("in_ready", in_ready, m_run && !s && (ordy || m_q.size() == 0));
    m_done = 1'b0;
    if (!r) begin
      m_q.delete(); m_run = 0; m_rnd = 0;
    end else if (s) begin
      m_q.delete(); m_run = 1; m_rnd = 0;
      expand(k);
    end else begin
      drain = (m_q.size() != 0) && ordy;
      acc   = m_run && v && (ordy || m_q.size() == 0);
      if (drain) void'(m_q.pop_front());
      if (acc) begin
        m_q.push_back(d ^ rk[m_rnd]);
        if (m_rnd == 10) begin
          m_run = 0; m_rnd = 0; m_done = 1;
        end else m_rnd++;
      end
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [127:0] k2, blk;
    build_sbox();
    m_run = 0; m_rnd = 0; m_done = 0;

    // reset held 3 cycles with in_valid asserted
    rst_n = 1'b0; start = 1'b0; key_in = '0; in_valid = 1'b1;
    in_data = rnd128(); out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_round", round, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_done", done, 0);

    // round 0 App. B vector
    cyc(1, 1, KEY, 0, 0, 1);
    cyc(1, 0, 0, 1, PT, 1);
    cyc(1, 0, 0, 0, 0, 0);
    chk("fips_r0", out_data, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
    chk("fips_r0_round", round, 1);

    // full key schedule with zero blocks
    cyc(1, 1, KEY, 0, 0, 1);
    for (int j = 1; j <= 11; j++) begin
      cyc(1, 0, 0, 1, 0, 1);
      if (j == 3) chk("ks_out2", out_data, 128'ha0fafe1788542cb123a339392a6c7605);
    end
    cyc(1, 0, 0, 1, 0, 1);
    chk("ks_out11", out_data, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("ks_done", done, 1);
    cyc(1, 0, 0, 1, 0, 1);
    chk("ks_done_clr", done, 0);
    chk("ks_busy_low", busy, 0);
    chk("idle_no_out", out_valid, 0);

    // backpressure
    cyc(1, 1, KEY, 0, 0, 1);
    cyc(1, 0, 0, 1, rnd128(), 0);
    blk = rnd128();
    repeat (4) cyc(1, 0, 0, 1, blk, 0);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_round_hold", round, 1);
    cyc(1, 0, 0, 1, blk, 1);
    chk("bp_release_ready", in_ready, 1);
    cyc(1, 0, 0, 0, 0, 1);
    chk("bp_next_block", out_data, blk ^ rk[1]);

    // abort at round 5 with a new key
    cyc(1, 1, KEY, 0, 0, 1);
    repeat (5) cyc(1, 0, 0, 1, rnd128(), 1);
    k2 = rnd128();
    cyc(1, 1, k2, 1, rnd128(), 1);
    blk = rnd128();
    cyc(1, 0, 0, 1, blk, 1);
    chk("abort_valid", out_valid, 0);
    chk("abort_round", round, 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("abort_newkey", out_data, blk ^ k2);

    // reset in the middle of a run
    cyc(1, 1, rnd128(), 0, 0, 1);
    repeat (7) cyc(1, 0, 0, 1, rnd128(), 1);
    cyc(0, 0, 0, 1, rnd128(), 1);
    cyc(1, 0, 0, 1, rnd128(), 1);
    chk("mrst_out_data", out_data, 0);
    chk("mrst_round", round, 0);
    cyc(1, 1, KEY, 0, 0, 1);
    cyc(1, 0, 0, 1, PT, 1);
    cyc(1, 0, 0, 0, 0, 0);
    chk("mrst_fips_r0", out_data, 128'h193de3bea0f4e22b9ac68d2ae9f84808);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++)
      cyc(1, $urandom_range(0, 39) == 0, rnd128(),
          $urandom_range(0, 9) < 7, rnd128(), $urandom_range(0, 9) < 7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
